// File: rtl/diff_addr_gen.sv
// diff_addr_gen: row-major (dx) / column-major (dy) address sequencer for the difference stages.
// Optional multi-frame sweeps: define DIFF_ADDR_FRAMES_EN to add the f_num port and frame counter.
module diff_addr_gen #(
  parameter int ADDR_W     = 8,
  parameter int COL_WIDTH  = 4,
  parameter int ROW_NUM    = 48,
  parameter int BASE       = 0,
  parameter int FRAMES_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              en,
`ifdef DIFF_ADDR_FRAMES_EN
  input  logic [$clog2(FRAMES_MAX+1)-1:0] f_num,
`endif
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_vld,
  output logic              diff_clr,
  output logic              line_last,
  output logic              done
);

  if (ADDR_W < 1 || COL_WIDTH < 1 || ROW_NUM < 1 || FRAMES_MAX < 1) begin : g_param_check
    $error("diff_addr_gen: ADDR_W, COL_WIDTH, ROW_NUM and FRAMES_MAX must all be >= 1");
  end

  localparam int CW = (COL_WIDTH > 1) ? $clog2(COL_WIDTH) : 1;
  localparam int RW = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(COL_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(ROW_NUM - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              mode_q, mode_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              busy_q, busy_d;
  logic              vld_q, vld_d;
  logic              clr_q, clr_d;
  logic              last_q, last_d;
  logic              done_q, done_d;

  logic              col_first, col_last;
  logic              row_first, row_last;
  logic              frm_last;
  logic [31:0]       frm_base;
  logic [31:0]       idx;
  logic [ADDR_W-1:0] emit_addr;

`ifdef DIFF_ADDR_FRAMES_EN
  localparam int FW = (FRAMES_MAX > 1) ? $clog2(FRAMES_MAX) : 1;

  // frm_lim holds nframes-1, so f_num=0 and f_num=1 both give a single frame
  logic [FW-1:0] frm_q, frm_d;
  logic [FW-1:0] frm_lim_q, frm_lim_d;
  logic [FW-1:0] f_num_lim;

  always_comb begin
    if (f_num == '0) begin
      f_num_lim = '0;
    end else if (32'(f_num) > 32'(FRAMES_MAX)) begin
      f_num_lim = FW'(FRAMES_MAX - 1);
    end else begin
      f_num_lim = FW'(32'(f_num) - 32'd1);
    end
  end

  assign frm_last = (frm_q == frm_lim_q);
  assign frm_base = 32'(frm_q) * 32'(ROW_NUM * COL_WIDTH);
`else
  assign frm_last = 1'b1;
  assign frm_base = '0;
`endif

  assign col_first = (col_q == '0);
  assign col_last  = (col_q == COL_MAX);
  assign row_first = (row_q == '0);
  assign row_last  = (row_q == ROW_MAX);

  assign idx       = frm_base + 32'(row_q) * 32'(COL_WIDTH) + 32'(col_q);
  assign emit_addr = ADDR_W'(idx + 32'(BASE));

  // done_q marks the tail of the sweep; start is refused then so a restart waits one more cycle
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = addr_q;
    vld_d   = 1'b0;
    clr_d   = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;
`ifdef DIFF_ADDR_FRAMES_EN
    frm_d     = frm_q;
    frm_lim_d = frm_lim_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start && !done_q) begin
          state_d = ST_RUN;
          mode_d  = mode;
          col_d   = '0;
          row_d   = '0;
`ifdef DIFF_ADDR_FRAMES_EN
          frm_d     = '0;
          frm_lim_d = f_num_lim;
`endif
        end
      end

      ST_RUN: begin
        if (en) begin
          addr_d = emit_addr;
          vld_d  = 1'b1;
          clr_d  = mode_q ? row_first : col_first;
          last_d = mode_q ? row_last  : col_last;

          if (!mode_q) begin
            col_d = col_last ? '0 : col_q + CW'(1);
            if (col_last) begin
              row_d = row_last ? '0 : row_q + RW'(1);
            end
          end else begin
            row_d = row_last ? '0 : row_q + RW'(1);
            if (row_last) begin
              col_d = col_last ? '0 : col_q + CW'(1);
            end
          end

          // Both orders finish a frame on the same corner (last column, last row)
          if (col_last && row_last) begin
            if (frm_last) begin
              state_d = ST_DONE;
            end
`ifdef DIFF_ADDR_FRAMES_EN
            else begin
              frm_d = frm_q + FW'(1);
            end
`endif
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d != ST_IDLE) || (state_q == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
      clr_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DIFF_ADDR_FRAMES_EN
      frm_q     <= '0;
      frm_lim_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      col_q   <= col_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
      clr_q   <= clr_d;
      last_q  <= last_d;
      done_q  <= done_d;
`ifdef DIFF_ADDR_FRAMES_EN
      frm_q     <= frm_d;
      frm_lim_q <= frm_lim_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign addr      = addr_q;
  assign addr_vld  = vld_q;
  assign diff_clr  = clr_q;
  assign line_last = last_q;
  assign done      = done_q;

endmodule
